// File: rtl/float8_pkg.sv
// float8_pkg: float8 field layout, special encodings and accumulator state encoding.
`default_nettype none

package float8_pkg;

   localparam int SIGN_BIT = 7;
   localparam int EXP_MSB  = 6;
   localparam int EXP_LSB  = 4;
   localparam int MAN_W    = 4;
   localparam int EXP_BIAS = 4;

   localparam logic [7:0] FLOAT8_ZERO    = 8'h00;
   localparam logic [7:0] FLOAT8_MAX_POS = 8'h7F;
   localparam logic [7:0] FLOAT8_MAX_NEG = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/Float8Adder.sv
// Float8Adder: combinational float8 adder; exponent 0 reads as zero, results truncate,
// overflow saturates to the signed maximum, underflow flushes to 0x00.
`default_nettype none

module Float8Adder
   import float8_pkg::*;
(
   input  logic [7:0] iNum1,
   input  logic [7:0] iNum2,
   output logic [7:0] oNum,
   output logic       overflow
);

   logic [2:0]         exp_a, exp_b, exp_big, exp_sml;
   logic [MAN_W:0]     frac_a, frac_b, frac_big, frac_sml;
   logic               swap, sign_big, sign_sml;
   logic [2*MAN_W:0]   mag_big, mag_sml;
   logic [2*MAN_W+1:0] sum;
   logic [3:0]         lz;
   logic [MAN_W-1:0]   man_res;
   logic signed [4:0]  exp_res;

   function automatic logic [3:0] lead_zeros(input logic [8:0] v);
      logic [3:0] n;
      n = 4'd9;
      for (int i = 0; i <= 8; i++) begin
         if (v[i]) n = 4'(8 - i);
      end
      return n;
   endfunction

   function automatic logic [3:0] norm_man(input logic [8:0] v, input logic [3:0] sh);
      logic [8:0] t;
      t = v << sh;
      return t[7:4];
   endfunction

   always_comb begin
      exp_a  = iNum1[EXP_MSB:EXP_LSB];
      exp_b  = iNum2[EXP_MSB:EXP_LSB];
      frac_a = (exp_a == 3'd0) ? '0 : {1'b1, iNum1[MAN_W-1:0]};
      frac_b = (exp_b == 3'd0) ? '0 : {1'b1, iNum2[MAN_W-1:0]};

      // Order operands by magnitude so the subtraction below never goes negative.
      swap     = {exp_b, frac_b} > {exp_a, frac_a};
      sign_big = swap ? iNum2[SIGN_BIT] : iNum1[SIGN_BIT];
      sign_sml = swap ? iNum1[SIGN_BIT] : iNum2[SIGN_BIT];
      exp_big  = swap ? exp_b  : exp_a;
      exp_sml  = swap ? exp_a  : exp_b;
      frac_big = swap ? frac_b : frac_a;
      frac_sml = swap ? frac_a : frac_b;

      mag_big = {frac_big, {MAN_W{1'b0}}};
      mag_sml = {frac_sml, {MAN_W{1'b0}}} >> (exp_big - exp_sml);

      if (sign_big == sign_sml) sum = {1'b0, mag_big} + {1'b0, mag_sml};
      else                      sum = {1'b0, mag_big} - {1'b0, mag_sml};

      lz = lead_zeros(sum[8:0]);
      if (sum[9]) begin
         exp_res = $signed({2'b00, exp_big}) + 5'sd1;
         man_res = sum[8:5];
      end else begin
         exp_res = $signed({2'b00, exp_big}) - $signed({1'b0, lz});
         man_res = norm_man(sum[8:0], lz);
      end

      oNum     = FLOAT8_ZERO;
      overflow = 1'b0;
      if (sum != '0) begin
         if (exp_res > 5'sd7) begin
            overflow = 1'b1;
            oNum     = sign_big ? FLOAT8_MAX_NEG : FLOAT8_MAX_POS;
         end else if (exp_res >= 5'sd1) begin
            oNum = {sign_big, exp_res[2:0], man_res};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/float8_accumulator.sv
// float8_accumulator: sums N_TERMS float8 terms per group through one Float8Adder.
// Optional FLOAT8_ACC_RELU_EN clamps negative results (including 0x80) to 0x00.
`default_nettype none

module float8_accumulator
   import float8_pkg::*;
#(
   parameter int N_TERMS = 16,
   parameter int CNT_W   = 16
)(
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iValid,
   input  logic [7:0] iNum,
   output logic       oReady,
   output logic       oValid,
   input  logic       iOutReady,
   output logic [7:0] oSum,
   output logic       oOverflow
);

   state_e           state_q, state_d;
   logic [7:0]       acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             ready_q, ready_d;
   logic [7:0]       add_sum;
   logic             add_ovf;
   logic             accept, last_term;

   Float8Adder u_adder (
      .iNum1    (acc_q),
      .iNum2    (iNum),
      .oNum     (add_sum),
      .overflow (add_ovf)
   );

   assign accept    = iValid & ready_q;
   assign last_term = (cnt_q == CNT_W'(N_TERMS - 1));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE, ST_ACC: begin
            if (accept) begin
               acc_d   = add_sum;
               ovf_d   = ovf_q | add_ovf;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = last_term ? ST_DONE : ST_ACC;
            end
         end
         ST_DONE: begin
            if (iOutReady) begin
               state_d = ST_IDLE;
               acc_d   = FLOAT8_ZERO;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered ready keeps it low during reset and for the cycle after release.
      ready_d = (state_d != ST_DONE);
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= ST_IDLE;
         acc_q   <= FLOAT8_ZERO;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
      end
   end

   assign oReady    = ready_q;
   assign oValid    = (state_q == ST_DONE);
   assign oOverflow = oValid & ovf_q;

`ifdef FLOAT8_ACC_RELU_EN
   assign oSum = (oValid && !acc_q[SIGN_BIT]) ? acc_q : FLOAT8_ZERO;
`else
   assign oSum = oValid ? acc_q : FLOAT8_ZERO;
`endif

endmodule

`default_nettype wire

// File: tb/tb_float8_accumulator.sv
// tb_float8_accumulator: directed tests on three accumulators (N_TERMS = 4, 2, 3).
`default_nettype none

module tb_float8_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid[3];
   logic [7:0] num[3];
   logic       ready[3];
   logic       ovalid[3];
   logic       outready[3];
   logic [7:0] sum[3];
   logic       ovf[3];
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   float8_accumulator #(.N_TERMS(4), .CNT_W(16)) u_acc4 (
      .iClk(clk), .iRst_n(rst_n), .iValid(valid[0]), .iNum(num[0]), .oReady(ready[0]),
      .oValid(ovalid[0]), .iOutReady(outready[0]), .oSum(sum[0]), .oOverflow(ovf[0]));
   float8_accumulator #(.N_TERMS(2), .CNT_W(16)) u_acc2 (
      .iClk(clk), .iRst_n(rst_n), .iValid(valid[1]), .iNum(num[1]), .oReady(ready[1]),
      .oValid(ovalid[1]), .iOutReady(outready[1]), .oSum(sum[1]), .oOverflow(ovf[1]));
   float8_accumulator #(.N_TERMS(3), .CNT_W(16)) u_acc3 (
      .iClk(clk), .iRst_n(rst_n), .iValid(valid[2]), .iNum(num[2]), .oReady(ready[2]),
      .oValid(ovalid[2]), .iOutReady(outready[2]), .oSum(sum[2]), .oOverflow(ovf[2]));

   // Presents one term and returns #1 after the edge that accepts it.
   task automatic send(input int k, input logic [7:0] t);
      int n;
      n = 0;
      valid[k] = 1'b1;
      num[k]   = t;
      while (ready[k] !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         checks++; failures++;
         $display("FAIL send_timeout: dut %0d ready=%b required 1", k, ready[k]);
      end else begin
         @(posedge clk); #1;
      end
      valid[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valid[i] = 1'b0; num[i] = 8'h00; outready[i] = 1'b1;
      end
      #2;
      checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b required 0", ready[0]); end
      checks++; if (ovalid[0] !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", ovalid[0]); end
      checks++; if (sum[0] !== 8'h00) begin failures++; $display("FAIL reset_sum: got %h required 00", sum[0]); end
      checks++; if (ovf[0] !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", ovf[0]); end
      @(negedge clk); rst_n = 1'b1;
      #1;
      checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL release_ready_early: got %b required 0", ready[0]); end
      @(posedge clk); #1;
      checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL release_ready: got %b required 1", ready[0]); end
   endtask

   task automatic test_sum();
      send(0, 8'h20); send(0, 8'h20); send(0, 8'h40); send(0, 8'h00);
      checks++; if (ovalid[0] !== 1'b1) begin failures++; $display("FAIL sum_valid: got %b required 1", ovalid[0]); end
      checks++; if (sum[0] !== 8'h48) begin failures++; $display("FAIL sum_value: got %h required 48", sum[0]); end
      checks++; if (ovf[0] !== 1'b0) begin failures++; $display("FAIL sum_ovf: got %b required 0", ovf[0]); end
      checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL sum_done_ready: got %b required 0", ready[0]); end
      @(posedge clk); #1;
      checks++; if (ovalid[0] !== 1'b0) begin failures++; $display("FAIL sum_release_valid: got %b required 0", ovalid[0]); end
      checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL sum_release_ready: got %b required 1", ready[0]); end
   endtask

   task automatic test_cancel();
      send(1, 8'h38); send(1, 8'hB8);
      checks++; if (ovalid[1] !== 1'b1) begin failures++; $display("FAIL cancel_valid: got %b required 1", ovalid[1]); end
      checks++; if (sum[1] !== 8'h00) begin failures++; $display("FAIL cancel_value: got %h required 00", sum[1]); end
      checks++; if (ovf[1] !== 1'b0) begin failures++; $display("FAIL cancel_ovf: got %b required 0", ovf[1]); end
      @(posedge clk); #1;
   endtask

   task automatic test_overflow();
      send(2, 8'h7F); send(2, 8'h7F); send(2, 8'h00);
      checks++; if (ovalid[2] !== 1'b1) begin failures++; $display("FAIL ovf_valid: got %b required 1", ovalid[2]); end
      checks++; if (ovf[2] !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", ovf[2]); end
      @(posedge clk); #1;
      send(2, 8'h20); send(2, 8'h20); send(2, 8'h00);
      checks++; if (ovf[2] !== 1'b0) begin failures++; $display("FAIL ovf_cleared: got %b required 0", ovf[2]); end
      checks++; if (sum[2] !== 8'h30) begin failures++; $display("FAIL ovf_next_sum: got %h required 30", sum[2]); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      outready[0] = 1'b0;
      send(0, 8'h40); send(0, 8'h40); send(0, 8'h40); send(0, 8'h40);
      valid[0] = 1'b1;
      num[0]   = 8'h70;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (ovalid[0] !== 1'b1) begin failures++; $display("FAIL bp_valid: cycle %0d got %b required 1", c, ovalid[0]); end
         checks++; if (sum[0] !== 8'h60) begin failures++; $display("FAIL bp_sum: cycle %0d got %h required 60", c, sum[0]); end
         checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL bp_ready: cycle %0d got %b required 0", c, ready[0]); end
      end
      @(posedge clk); #1;
      valid[0]    = 1'b0;
      outready[0] = 1'b1;
      @(posedge clk); #1;
      checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b required 1", ready[0]); end
      send(0, 8'h20); send(0, 8'h20); send(0, 8'h20); send(0, 8'h20);
      checks++; if (sum[0] !== 8'h40) begin failures++; $display("FAIL bp_next_sum: got %h required 40", sum[0]); end
      @(posedge clk); #1;
   endtask

   task automatic test_relu();
      logic [7:0] exp_sum;
`ifdef FLOAT8_ACC_RELU_EN
      exp_sum = 8'h00;
`else
      exp_sum = 8'hB8;
`endif
      send(1, 8'hC0); send(1, 8'h20);
      checks++; if (sum[1] !== exp_sum) begin failures++; $display("FAIL relu_sum: got %h required %h", sum[1], exp_sum); end
      checks++; if (ovf[1] !== 1'b0) begin failures++; $display("FAIL relu_ovf: got %b required 0", ovf[1]); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      outready[1] = 1'b0;
      send(1, 8'h38); send(1, 8'h38);
      checks++; if (sum[1] !== 8'h48) begin failures++; $display("FAIL rst_done_sum: got %h required 48", sum[1]); end
      send(0, 8'h40); send(0, 8'h40);
      @(negedge clk); rst_n = 1'b0;
      #1;
      checks++; if (ovalid[1] !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b required 0", ovalid[1]); end
      checks++; if (sum[1] !== 8'h00) begin failures++; $display("FAIL rst_mid_sum: got %h required 00", sum[1]); end
      checks++; if (ready[0] !== 1'b0) begin failures++; $display("FAIL rst_mid_ready: got %b required 0", ready[0]); end
      @(negedge clk); rst_n = 1'b1; outready[1] = 1'b1;
      @(posedge clk); #1;
      send(0, 8'h40); send(0, 8'h20); send(0, 8'h20); send(0, 8'h00);
      checks++; if (sum[0] !== 8'h48) begin failures++; $display("FAIL rst_fresh_sum: got %h required 48", sum[0]); end
      checks++; if (ovalid[0] !== 1'b1) begin failures++; $display("FAIL rst_fresh_valid: got %b required 1", ovalid[0]); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_sum();
      test_cancel();
      test_overflow();
      test_back_to_back();
      test_relu();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/float8_accumulator.md
Name: float8_accumulator

Overview:
- Sequential accumulation stage directly downstream of the Float8Adder combinational adder in the TPU datapath.
- Takes a stream of float8 terms (neuron products) and sums exactly N_TERMS of them per neuron. It feeds each term and the running sum through one Float8Adder instance and registers the result.
- Emits one float8 neuron sum per group, plus a sticky overflow flag, to the activation/argmax logic downstream.

Parameters:
- N_TERMS, 16, number of terms summed per output; legal range 1..65535.
- CNT_W, 16, counter width; must satisfy 2^CNT_W > N_TERMS.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iValid  input  1  upstream term valid.
- iNum  input  8  float8 term: [7] sign, [6:4] exponent (bias 4), [3:0] mantissa (hidden 1); 0x00 = zero.
- oReady  output  1  block can accept a term this cycle.
- oValid  output  1  oSum/oOverflow valid.
- iOutReady  input  1  downstream accepts the result.
- oSum  output  8  accumulated float8 sum.
- oOverflow  output  1  set if any addition in this group overflowed.

Behaviour:
- Reset (async, iRst_n=0): state=IDLE, acc=0x00, cnt=0, oValid=0, oSum=0x00, oOverflow=0, oReady=0. oReady rises in the first cycle after reset release.
- States:
  - IDLE: acc=0x00, cnt=0, oReady=1. An accepted term goes to ACC, or to DONE if N_TERMS=1.
  - ACC: oReady=1.
  - DONE: oReady=0, oValid=1.
- Term accepted on a rising edge with iValid & oReady:
  - acc <= Float8Adder(acc, iNum).oNum
  - ovf_sticky <= ovf_sticky | overflow
  - cnt <= cnt+1
- Latency: one cycle per term, no bubbles. The N_TERMS-th accepted term moves to DONE on the same edge. oValid is high the next cycle.
- DONE:
  - oSum = acc and oOverflow = ovf_sticky, held stable while oValid=1 & iOutReady=0.
  - On oValid & iOutReady: return to IDLE; acc, cnt and sticky cleared. oReady=1 the following cycle (one bubble per group).
- iValid while oReady=0 is ignored; upstream must hold the term.
- -0 (0x80) as acc or term is treated exactly as the adder treats it. This block performs no arithmetic beyond the adder.
- After an overflow, acc takes whatever oNum the adder produces. Accumulation continues; only the flag is sticky.
- Counter compares cnt == N_TERMS-1 at acceptance and never wraps within a group.
- Reset asserted mid-group or in DONE: the group is discarded and all outputs return to reset values immediately.

Optional Feature:
- Macro: FLOAT8_ACC_RELU_EN.
- Defined: in DONE, oSum = 0x00 when acc[7]=1 (any negative value, including 0x80); otherwise oSum = acc. oOverflow is unaffected.
- Undefined: oSum = acc unchanged.

Decomposition:
- Package float8_pkg holds:
  - SIGN_BIT=7, EXP_MSB=6, EXP_LSB=4, MAN_W=4, EXP_BIAS=4
  - FLOAT8_ZERO=8'h00, FLOAT8_MAX_POS=8'h7F, FLOAT8_MAX_NEG=8'hFF
  - state encoding IDLE/ACC/DONE
- Sub-module: the existing Float8Adder, instantiated once (iNum1=acc, iNum2=iNum, oNum, overflow). No new sub-module is needed.
- FSM, counter and output register are local to float8_accumulator.

Test Plan:
- Sum: N_TERMS=4, iOutReady=1, terms 0x20,0x20,0x40,0x00 back-to-back -> oValid one cycle after 4th accept, oSum=0x48 (1.5), oOverflow=0.
- Cancellation: N_TERMS=2, terms 0x38,0xB8 -> oSum=0x00, oOverflow=0.
- Overflow: N_TERMS=3, terms 0x7F,0x7F,0x00 -> oOverflow=1, flag stays 1 through the 3rd term; the next group of 0x20,0x20,0x00 -> oOverflow=0.
- Backpressure: iOutReady=0 for 5 cycles in DONE -> oReady=0, oValid/oSum stable, extra iValid terms not consumed. Release -> IDLE, new group sums correctly.
- ReLU: N_TERMS=2, terms 0xC0,0x20 -> oSum=0xB8 (-0.75) without FLOAT8_ACC_RELU_EN, 0x00 with it.
- Reset: assert iRst_n=0 after 2 of 4 terms -> oValid=0, oSum=0x00 immediately. After release, a fresh 4-term group sums from zero.
